reg_scoreboard: RTL and testbench

- Parametrised register-index decoder with state: one-hot decodes destination indices into a per-register pending-write vector.
- Issue sets a pending bit; writeback clears it; read-side lookups report RAW busy, and issue reports a WAW stall.
- Sits between decode and the register file in haze-cpu and drives the pipeline stall logic.
- Generalises the fixed 5-to-32 decode to any index width, with an optional hardwired zero register and an optional writeback bypass.

---
 rtl/reg_scoreboard.sv | 97 +++++++++
 tb/tb_reg_scoreboard.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks pending writes per register, reports RAW busy and WAW issue stall.
// Issue sets a pending bit, writeback clears it, and flush clears all of them; o_ERR is sticky.
module reg_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 2 ** ADDR_WIDTH,
  parameter int unsigned ZERO_REG   = 1,
  parameter int unsigned WB_BYPASS  = 1
) (
  input  logic                  i_CLK,
  input  logic                  i_RSTn,
  input  logic                  i_FLUSH,
  input  logic                  i_ISSUE_VALID,
  input  logic [ADDR_WIDTH-1:0] i_ISSUE_RD,
  output logic                  o_ISSUE_READY,
  input  logic                  i_WB_VALID,
  input  logic [ADDR_WIDTH-1:0] i_WB_RD,
  input  logic [ADDR_WIDTH-1:0] i_RS1,
  input  logic [ADDR_WIDTH-1:0] i_RS2,
  output logic                  o_RS1_BUSY,
  output logic                  o_RS2_BUSY,
  output logic [NUM_REGS-1:0]   o_PENDING,
  output logic [ADDR_WIDTH:0]   o_COUNT,
  output logic                  o_ERR
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [NUM_REGS-1:0] ONE   = NUM_REGS'(1);
  localparam logic [NUM_REGS-1:0] ZMASK = (ZERO_REG != 0) ? ~ONE : '1;

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CW-1:0]       count_q, count_d;
  logic                err_q, err_d;

  logic [NUM_REGS-1:0] iss_oh, wb_oh;
  logic                issue_accept, iss_set, wb_hit, wb_clr;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  // One-hot decode; out-of-range indices decode to zero.
  function automatic logic [NUM_REGS-1:0] dec(input logic [ADDR_WIDTH-1:0] idx);
    return in_range(idx) ? (ONE << idx) : '0;
  endfunction

  function automatic logic busy(input logic [ADDR_WIDTH-1:0] rs,
                                input logic [NUM_REGS-1:0]   pend,
                                input logic                  wb_v,
                                input logic [ADDR_WIDTH-1:0] wb_rd);
    logic b;
    b = |(pend & dec(rs) & ZMASK);
    if ((WB_BYPASS != 0) && wb_v && (wb_rd == rs)) b = 1'b0;
    return b;
  endfunction

  always_comb begin
    pending_d    = pending_q;
    count_d      = count_q;
    err_d        = err_q;
    iss_oh       = dec(i_ISSUE_RD) & ZMASK;
    wb_oh        = dec(i_WB_RD);
    o_ISSUE_READY = ~(|(pending_q & dec(i_ISSUE_RD)));
    issue_accept = i_ISSUE_VALID & o_ISSUE_READY;
    iss_set      = issue_accept & (|iss_oh);
    wb_hit       = |(pending_q & wb_oh);
    wb_clr       = i_WB_VALID & wb_hit;
    o_RS1_BUSY   = busy(i_RS1, pending_q, i_WB_VALID, i_WB_RD);
    o_RS2_BUSY   = busy(i_RS2, pending_q, i_WB_VALID, i_WB_RD);

    if (i_FLUSH) begin
      pending_d = '0;
      count_d   = '0;
    end else begin
      if (issue_accept && !in_range(i_ISSUE_RD)) err_d = 1'b1;
      if (i_WB_VALID && !wb_hit) err_d = 1'b1;
      pending_d = (pending_q | (iss_set ? iss_oh : '0)) & ~(wb_clr ? wb_oh : '0);
      count_d   = count_q + CW'(iss_set) - CW'(wb_clr);
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      pending_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign o_PENDING = pending_q;
  assign o_COUNT   = count_q;
  assign o_ERR     = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard with default parameters (32 regs, zero reg, bypass).
module tb_reg_scoreboard;

  logic        clk, rst_n, flush;
  logic        iss_v, wb_v;
  logic [4:0]  iss_rd, wb_rd, rs1, rs2;
  logic        ready, busy1, busy2, err;
  logic [31:0] pending;
  logic [5:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  reg_scoreboard dut (
    .i_CLK(clk), .i_RSTn(rst_n), .i_FLUSH(flush),
    .i_ISSUE_VALID(iss_v), .i_ISSUE_RD(iss_rd), .o_ISSUE_READY(ready),
    .i_WB_VALID(wb_v), .i_WB_RD(wb_rd), .i_RS1(rs1), .i_RS2(rs2),
    .o_RS1_BUSY(busy1), .o_RS2_BUSY(busy2),
    .o_PENDING(pending), .o_COUNT(count), .o_ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running, expected done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later, then drop the one-cycle request strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    iss_v = 1'b0;
    wb_v  = 1'b0;
    flush = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd);
    iss_v  = 1'b1;
    iss_rd = rd;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; iss_v = 1'b0; wb_v = 1'b0;
    iss_rd = 5'd5; wb_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    #23;
    chk("rst_pending", pending, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;
    tick();

    issue(5'd5);
    chk("iss5_pending", pending, 32'h0000_0020);
    chk("iss5_count", 32'(count), 32'd1);
    rs1 = 5'd5; #1;
    chk("iss5_rs1_busy", 32'(busy1), 32'd1);
    chk("iss5_ready", 32'(ready), 32'd0);

    wb_v = 1'b1; wb_rd = 5'd5; rs2 = 5'd5; #1;
    chk("bypass_rs2_busy", 32'(busy2), 32'd0);
    chk("wb_same_ready", 32'(ready), 32'd0);
    tick();
    chk("wb5_pending", pending, 32'h0);
    chk("wb5_count", 32'(count), 32'd0);
    chk("wb5_err", 32'(err), 32'd0);

    issue(5'd0);
    chk("zero_pending", pending, 32'h0);
    chk("zero_count", 32'(count), 32'd0);
    rs1 = 5'd0; #1;
    chk("zero_rs1_busy", 32'(busy1), 32'd0);

    wb_v = 1'b1; wb_rd = 5'd7;
    tick();
    chk("wb_nonpend_err", 32'(err), 32'd1);
    chk("wb_nonpend_pending", pending, 32'h0);
    tick();
    chk("err_sticky", 32'(err), 32'd1);

    issue(5'd3);
    issue(5'd9);
    chk("p3_9_pending", pending, 32'h0000_0208);
    rs1 = 5'd9; rs2 = 5'd4; #1;
    chk("rs1_9_busy", 32'(busy1), 32'd1);
    chk("rs2_4_busy", 32'(busy2), 32'd0);
    iss_v = 1'b1; iss_rd = 5'd12; wb_v = 1'b1; wb_rd = 5'd3;
    tick();
    chk("iss_wb_pending", pending, 32'h0000_1200);
    chk("iss_wb_count", 32'(count), 32'd2);

    for (int i = 1; i < 32; i++) issue(5'(i));
    chk("full_pending", pending, 32'hFFFF_FFFE);
    chk("full_count", 32'(count), 32'd31);
    iss_rd = 5'd0; #1;
    chk("full_ready0", 32'(ready), 32'd1);

    flush = 1'b1; iss_v = 1'b1; iss_rd = 5'd0; wb_v = 1'b1; wb_rd = 5'd4;
    tick();
    chk("flush_pending", pending, 32'h0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_err", 32'(err), 32'd1);

    for (int i = 1; i <= 4; i++) issue(5'(i));
    chk("four_count", 32'(count), 32'd4);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pending", pending, 32'h0);
    chk("async_count", 32'(count), 32'd0);
    chk("async_err", 32'(err), 32'd0);
    #1 rst_n = 1'b1;
    tick();

    issue(5'd2);
    chk("post_rst_pending", pending, 32'h0000_0004);
    chk("post_rst_count", 32'(count), 32'd1);
    issue(5'd2);
    chk("waw_stall_count", 32'(count), 32'd1);
    wb_v = 1'b1; wb_rd = 5'd2;
    tick();
    chk("final_pending", pending, 32'h0);
    chk("final_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
